// File: rtl/huff_pkg.sv
// huff_pkg: shared constants and types for the Huffman pipeline stages
package huff_pkg;

    localparam int NSYM      = 6;
    localparam int SYM_W     = 3;
    localparam int CNT_W_DEF = 8;
    localparam int PASS_LAST = 5;

    typedef enum logic {IDLE, SORT} state_t;

    typedef struct packed {
        logic [SYM_W-1:0]     sym;
        logic [CNT_W_DEF-1:0] cnt;
    } slot_t;

endpackage

// File: rtl/cnt_cmp_swap.sv
// cnt_cmp_swap: compare-exchange cell; larger count goes to hi, equal counts keep the lower symbol ID in hi
module cnt_cmp_swap
    import huff_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [SYM_W+CNT_W-1:0] a,
    input  logic [SYM_W+CNT_W-1:0] b,
    output logic [SYM_W+CNT_W-1:0] hi,
    output logic [SYM_W+CNT_W-1:0] lo
);

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } cslot_t;

    cslot_t sa;
    cslot_t sb;
    logic   swap;

    assign sa   = a;
    assign sb   = b;
    assign swap = (sb.cnt > sa.cnt) || ((sb.cnt == sa.cnt) && (sb.sym < sa.sym));
    assign hi   = swap ? b : a;
    assign lo   = swap ? a : b;

endmodule

// File: rtl/cnt_sorter.sv
// cnt_sorter: captures six symbol counts and sorts them by odd-even transposition (optional CNT_SORTER_CHECKSUM_EN adds sum_err)
module cnt_sorter
    import huff_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef CNT_SORTER_CHECKSUM_EN
    ,
    parameter int EXP_TOTAL = 100
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   CNT_valid,
    input  logic [CNT_W-1:0]       CNT1,
    input  logic [CNT_W-1:0]       CNT2,
    input  logic [CNT_W-1:0]       CNT3,
    input  logic [CNT_W-1:0]       CNT4,
    input  logic [CNT_W-1:0]       CNT5,
    input  logic [CNT_W-1:0]       CNT6,
    output logic                   busy,
    output logic                   sort_valid,
    output logic [SYM_W*NSYM-1:0]  sort_sym,
    output logic [CNT_W*NSYM-1:0]  sort_cnt
`ifdef CNT_SORTER_CHECKSUM_EN
    ,
    output logic                   sum_err
`endif
);

    localparam int SLOT_W = SYM_W + CNT_W;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [CNT_W-1:0] cnt;
    } cslot_t;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        pass;
    logic              odd;
    logic              last;
    logic              start;
    cslot_t            slot    [NSYM];
    cslot_t            slot_nx [NSYM];
    cslot_t            load    [NSYM];
    logic [SLOT_W-1:0] ca  [3];
    logic [SLOT_W-1:0] cb  [3];
    logic [SLOT_W-1:0] chi [3];
    logic [SLOT_W-1:0] clo [3];

    assign busy  = (state == SORT);
    assign odd   = pass[0];
    assign last  = (pass == 3'(PASS_LAST));
    assign start = !busy && CNT_valid;

    // Initial slot contents: slot k carries symbol k+1 and its count
    always_comb begin
        load[0] = '{sym: SYM_W'(1), cnt: CNT1};
        load[1] = '{sym: SYM_W'(2), cnt: CNT2};
        load[2] = '{sym: SYM_W'(3), cnt: CNT3};
        load[3] = '{sym: SYM_W'(4), cnt: CNT4};
        load[4] = '{sym: SYM_W'(5), cnt: CNT5};
        load[5] = '{sym: SYM_W'(6), cnt: CNT6};
    end

    // Operand routing: even passes pair (0,1)(2,3)(4,5); odd passes reuse cells 0,1 on (1,2)(3,4)
    always_comb begin
        ca[0] = odd ? slot[1] : slot[0];
        cb[0] = odd ? slot[2] : slot[1];
        ca[1] = odd ? slot[3] : slot[2];
        cb[1] = odd ? slot[4] : slot[3];
        ca[2] = slot[4];
        cb[2] = slot[5];
    end

    for (genvar i = 0; i < 3; i++) begin : g_cs
        cnt_cmp_swap #(.CNT_W(CNT_W)) u_cs (
            .a  (ca[i]),
            .b  (cb[i]),
            .hi (chi[i]),
            .lo (clo[i])
        );
    end

    // Slot contents after one pass; end slots pass through untouched on odd passes
    always_comb begin
        slot_nx[0] = odd ? slot[0] : cslot_t'(chi[0]);
        slot_nx[1] = odd ? cslot_t'(chi[0]) : cslot_t'(clo[0]);
        slot_nx[2] = odd ? cslot_t'(clo[0]) : cslot_t'(chi[1]);
        slot_nx[3] = odd ? cslot_t'(chi[1]) : cslot_t'(clo[1]);
        slot_nx[4] = odd ? cslot_t'(clo[1]) : cslot_t'(chi[2]);
        slot_nx[5] = odd ? slot[5] : cslot_t'(clo[2]);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: leave IDLE on an accepted frame, leave SORT after the last pass
    always_comb begin
        state_nx = (state == IDLE) ? (CNT_valid ? SORT : IDLE) : (last ? IDLE : SORT);
    end

    // Slot storage, pass counter and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot       <= '{default: '0};
            pass       <= '0;
            sort_valid <= 1'b0;
        end else begin
            sort_valid <= busy && last;
            if (start) begin
                slot <= load;
                pass <= '0;
            end else if (busy) begin
                slot <= slot_nx;
                pass <= last ? 3'd0 : pass + 3'd1;
            end
        end
    end

    for (genvar k = 0; k < NSYM; k++) begin : g_out
        assign sort_sym[SYM_W*k +: SYM_W] = slot[k].sym;
        assign sort_cnt[CNT_W*k +: CNT_W] = slot[k].cnt;
    end

`ifdef CNT_SORTER_CHECKSUM_EN
    localparam int SUM_W = CNT_W + 3;

    logic [SUM_W-1:0] sum;
    logic             sum_bad;

    assign sum = SUM_W'(CNT1) + SUM_W'(CNT2) + SUM_W'(CNT3)
               + SUM_W'(CNT4) + SUM_W'(CNT5) + SUM_W'(CNT6);

    // Record the checksum verdict at load and present it alongside sort_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_bad <= 1'b0;
            sum_err <= 1'b0;
        end else begin
            sum_err <= busy && last && sum_bad;
            if (start) sum_bad <= (sum != SUM_W'(EXP_TOTAL));
        end
    end
`endif

endmodule

// File: tb/tb_cnt_sorter.sv
// tb_cnt_sorter: scoreboard bench for cnt_sorter (checks sum_err when CNT_SORTER_CHECKSUM_EN is defined)
module tb_cnt_sorter;

    localparam int W = 8;

    typedef struct packed {
        logic [17:0] sym;
        logic [47:0] cnt;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        CNT_valid = 1'b0;
    logic [W-1:0] CNT1 = '0, CNT2 = '0, CNT3 = '0, CNT4 = '0, CNT5 = '0, CNT6 = '0;
    logic        busy;
    logic        sort_valid;
    logic [17:0] sort_sym;
    logic [47:0] sort_cnt;
`ifdef CNT_SORTER_CHECKSUM_EN
    logic        sum_err;
`endif

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   bc;

    cnt_sorter #(.CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .CNT_valid  (CNT_valid),
        .CNT1       (CNT1),
        .CNT2       (CNT2),
        .CNT3       (CNT3),
        .CNT4       (CNT4),
        .CNT5       (CNT5),
        .CNT6       (CNT6),
        .busy       (busy),
        .sort_valid (sort_valid),
        .sort_sym   (sort_sym),
        .sort_cnt   (sort_cnt)
`ifdef CNT_SORTER_CHECKSUM_EN
        ,
        .sum_err    (sum_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference: repeatedly pick the largest remaining count, lowest symbol ID on ties
    function automatic exp_t model(input logic [47:0] c);
        exp_t r;
        bit   used[6];
        int   best;
        int   sum;
        r   = '0;
        sum = 0;
        for (int i = 0; i < 6; i++) used[i] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            best = -1;
            for (int i = 0; i < 6; i++)
                if (!used[i] && (best < 0 || c[8*i +: 8] > c[8*best +: 8])) best = i;
            used[best] = 1'b1;
            r.sym[3*s +: 3] = 3'(best + 1);
            r.cnt[8*s +: 8] = c[8*best +: 8];
        end
        for (int i = 0; i < 6; i++) sum += int'(c[8*i +: 8]);
        r.err = (sum != 100);
        return r;
    endfunction

    // Drive one CNT_valid pulse (called at a negedge); optionally record the expected result
    task automatic pulse(input logic [47:0] c, input bit push);
        {CNT6, CNT5, CNT4, CNT3, CNT2, CNT1} = c;
        CNT_valid = 1'b1;
        if (push) sb.push_back(model(c));
        @(negedge clk);
        CNT_valid = 1'b0;
    endtask

    // Wait (bounded) for sort_valid; cyc = negedges waited or -1, b = negedges with busy high
    task automatic wait_valid(output int c, output int b);
        c = -1;
        b = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) b++;
            if (sort_valid) begin
                c = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        if (busy !== 1'b0) errors++;
        checks++; if (sort_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sort_valid); end
        checks++; if (sort_sym !== 18'd0) begin errors++; $display("FAIL reset_sym: got %h want 0", sort_sym); end
        checks++; if (sort_cnt !== 48'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", sort_cnt); end
`ifdef CNT_SORTER_CHECKSUM_EN
        checks++; if (sum_err !== 1'b0) begin errors++; $display("FAIL reset_sum_err: got %b want 0", sum_err); end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        pulse({8'd20, 8'd15, 8'd10, 8'd30, 8'd5, 8'd20}, 1'b1);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc != 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", cyc); end
        checks++; if (sort_sym !== {3'd2, 3'd4, 3'd5, 3'd6, 3'd1, 3'd3}) begin errors++; $display("FAIL basic_sym_const: got %h want %h", sort_sym, {3'd2, 3'd4, 3'd5, 3'd6, 3'd1, 3'd3}); end
        checks++; if (sort_cnt !== e.cnt) begin errors++; $display("FAIL basic_cnt: got %h want %h", sort_cnt, e.cnt); end
        checks++; if (sort_sym !== e.sym) begin errors++; $display("FAIL basic_sym: got %h want %h", sort_sym, e.sym); end
`ifdef CNT_SORTER_CHECKSUM_EN
        checks++; if (sum_err !== 1'b0) begin errors++; $display("FAIL basic_sum_err: got %b want 0", sum_err); end
`endif
        @(negedge clk);
        checks++; if (sort_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", sort_valid); end
        repeat (3) @(negedge clk);
        checks++; if (sort_sym !== e.sym || sort_cnt !== e.cnt) begin errors++; $display("FAIL basic_hold: got %h/%h want %h/%h", sort_sym, sort_cnt, e.sym, e.cnt); end
    endtask

    task automatic test_reverse;
        pulse({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (bc != 6) begin errors++; $display("FAIL reverse_busy_cycles: got %0d want 6", bc); end
        checks++; if (sort_sym !== {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}) begin errors++; $display("FAIL reverse_sym: got %h want %h", sort_sym, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}); end
        checks++; if (sort_cnt !== e.cnt) begin errors++; $display("FAIL reverse_cnt: got %h want %h", sort_cnt, e.cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reverse_busy_end: got %b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_zeros;
        pulse(48'd0, 1'b1);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc != 6) begin errors++; $display("FAIL zeros_latency: got %0d want 6", cyc); end
        checks++; if (sort_sym !== {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}) begin errors++; $display("FAIL zeros_sym: got %h want %h", sort_sym, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}); end
        checks++; if (sort_cnt !== 48'd0) begin errors++; $display("FAIL zeros_cnt: got %h want 0", sort_cnt); end
        @(negedge clk);
    endtask

    task automatic test_ignore;
        pulse({8'd9, 8'd40, 8'd40, 8'd7, 8'd1, 8'd3}, 1'b1);
        repeat (2) @(negedge clk);
        pulse({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 1'b0);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc != 3) begin errors++; $display("FAIL ignore_latency: got %0d want 3", cyc); end
        checks++; if (sort_sym !== e.sym) begin errors++; $display("FAIL ignore_sym: got %h want %h", sort_sym, e.sym); end
        checks++; if (sort_cnt !== e.cnt) begin errors++; $display("FAIL ignore_cnt: got %h want %h", sort_cnt, e.cnt); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        pulse({8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100}, 1'b1);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (sort_sym !== e.sym || sort_cnt !== e.cnt) begin errors++; $display("FAIL b2b_first: got %h/%h want %h/%h", sort_sym, sort_cnt, e.sym, e.cnt); end
        pulse({8'd3, 8'd3, 8'd200, 8'd3, 8'd0, 8'd3}, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc != 6) begin errors++; $display("FAIL b2b_latency: got %0d want 6", cyc); end
        checks++; if (sort_sym !== e.sym || sort_cnt !== e.cnt) begin errors++; $display("FAIL b2b_second: got %h/%h want %h/%h", sort_sym, sort_cnt, e.sym, e.cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit seen;
        pulse({8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66}, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (sort_sym !== 18'd0 || sort_cnt !== 48'd0) begin errors++; $display("FAIL midreset_outputs: got %h/%h want 0/0", sort_sym, sort_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sort_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midreset_no_valid: got sort_valid 1 want 0"); end
        pulse({8'd20, 8'd15, 8'd10, 8'd30, 8'd5, 8'd20}, 1'b1);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc != 6) begin errors++; $display("FAIL midreset_fresh_latency: got %0d want 6", cyc); end
        checks++; if (sort_sym !== e.sym || sort_cnt !== e.cnt) begin errors++; $display("FAIL midreset_fresh: got %h/%h want %h/%h", sort_sym, sort_cnt, e.sym, e.cnt); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [47:0] c;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 6; i++)
                c[8*i +: 8] = (n < 4) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            pulse(c, 1'b1);
            wait_valid(cyc, bc);
            e = sb.pop_front();
            checks++; if (sort_sym !== e.sym || sort_cnt !== e.cnt) begin errors++; $display("FAIL random_%0d: in %h got %h/%h want %h/%h", n, c, sort_sym, sort_cnt, e.sym, e.cnt); end
        end
        @(negedge clk);
    endtask

`ifdef CNT_SORTER_CHECKSUM_EN
    task automatic test_checksum;
        pulse({8'd19, 8'd15, 8'd10, 8'd30, 8'd5, 8'd20}, 1'b1);
        wait_valid(cyc, bc);
        e = sb.pop_front();
        checks++; if (sum_err !== e.err || e.err !== 1'b1) begin errors++; $display("FAIL checksum_bad: got %b want 1", sum_err); end
        checks++; if (sort_sym !== e.sym || sort_cnt !== e.cnt) begin errors++; $display("FAIL checksum_sort: got %h/%h want %h/%h", sort_sym, sort_cnt, e.sym, e.cnt); end
        @(negedge clk);
        checks++; if (sum_err !== 1'b0) begin errors++; $display("FAIL checksum_pulse: got %b want 0", sum_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reverse();
        test_zeros();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef CNT_SORTER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
